axis_sample_capture: RTL and testbench
======================================

AXIS_SAMPLE_CAPTURE -- requirements
Module: axis_sample_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, capture buffer depth in samples (power of two, 2..65536).
REQ-002 SHALL have derived parameter ADDR_W, default $clog2(DEPTH), buffer address width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port s_axis_tdata  input  32  I/Q sample: [31:16] I signed, [15:0] Q signed.
REQ-006 SHALL have port s_axis_tvalid  input  1  upstream sample valid.
REQ-007 SHALL have port s_axis_tready  output  1  sink ready.
REQ-008 SHALL have port arm  input  1  single-cycle capture start strobe.
REQ-009 SHALL have port abort  input  1  single-cycle capture cancel strobe.
REQ-010 SHALL have port cap_len  input  ADDR_W+1  samples to capture; sampled on arm.
REQ-011 SHALL have port cap_busy  output  1  high in CAPTURE.
REQ-012 SHALL have port cap_done  output  1  high in DONE.
REQ-013 SHALL have port cap_count  output  ADDR_W+1  samples stored in current/last capture.
REQ-014 SHALL have ports sum_i, sum_q  output  32 each  signed running sums of I and Q over captured samples.
REQ-015 SHALL have ports rd_en  input  1, rd_addr  input  ADDR_W, rd_data  output  32, rd_valid  output  1  buffer readback.

Function
REQ-016 SHALL accept a sample on any rising edge where s_axis_tvalid && s_axis_tready.
REQ-017 SHALL drive s_axis_tready = 1 in IDLE, CAPTURE and DONE; never stall upstream outside reset.
REQ-018 SHALL implement FSM states IDLE, CAPTURE, DONE.
REQ-019 IDLE: accepted samples discarded; arm -> CAPTURE, latching len = min(cap_len, DEPTH), clearing cap_count, sum_i, sum_q.
REQ-020 arm with cap_len = 0 SHALL go IDLE -> DONE directly with cap_count = 0, sums = 0.
REQ-021 CAPTURE: each accepted sample written to buffer[cap_count], cap_count += 1, sum_i += sext(I), sum_q += sext(Q), all on the accepting edge.
REQ-022 CAPTURE -> DONE on the edge accepting sample number len; cap_busy falls, cap_done rises on that same edge (registered outputs).
REQ-023 arm during CAPTURE SHALL be ignored.
REQ-024 arm in DONE SHALL restart capture exactly as from IDLE.
REQ-025 abort in CAPTURE or DONE SHALL go to IDLE next edge; cap_count, sums and buffer contents retained; sample on abort edge not stored.
REQ-026 arm and abort in the same cycle: abort wins.
REQ-027 DONE: accepted samples discarded; outputs hold until arm or abort.
REQ-028 Sums SHALL be 32-bit two's complement, wrapping on overflow (cannot occur for DEPTH <= 65536).
REQ-029 Readback: rd_en at edge k -> rd_data = buffer[rd_addr], rd_valid = 1 after edge k+1 (latency 1); rd_valid = 0 otherwise.
REQ-030 Readback SHALL be permitted in any state; same-cycle read and write to one address returns old data.

Reset
REQ-031 Assertion of rst_n low SHALL immediately force IDLE, s_axis_tready = 0, cap_busy = 0, cap_done = 0, cap_count = 0, sum_i = 0, sum_q = 0, rd_valid = 0, rd_data = 0.
REQ-032 s_axis_tready SHALL rise on the first edge after rst_n deassertion.
REQ-033 Buffer contents SHALL NOT be reset; reset mid-capture discards the capture.

Structure
REQ-034 Shared package SHALL hold IQ_I_W = 16, IQ_Q_W = 16, the I/Q field positions, the sum width (32), and the capture state enum.
REQ-035 Buffer SHALL be a sub-module capture_ram: simple dual-port synchronous RAM, one write port, one read port, 1-cycle read latency.

Verification
REQ-036 arm, cap_len=4; samples I/Q = (1,-1),(2,-2),(3,-3),(4,-4) back-to-back -> cap_done after 4th accept, cap_count=4, sum_i=10, sum_q=-10.
REQ-037 arm, cap_len=3 with tvalid gaps of 2 cycles; then read addr 0..2 -> rd_data matches inputs, rd_valid 1 cycle after each rd_en.
REQ-038 arm, cap_len=0 -> cap_done next cycle, cap_busy never high, sums 0.
REQ-039 arm, cap_len=8; abort after 3 samples with arm same cycle -> IDLE, cap_count=3, no restart; further samples not stored.
REQ-040 cap_len=DEPTH+1 -> exactly DEPTH stored; I=0x8000 every sample with DEPTH=1024 -> sum_i = -33554432.
REQ-041 rst_n low mid-capture after 5 samples -> all outputs at reset values immediately; tready 1 one edge after release.

Source files
------------

// File: rtl/axis_sample_capture_pkg.sv
// Shared definitions for the I/Q sample capture block: field layout,
// accumulator width and capture FSM state encoding.
package axis_sample_capture_pkg;

   localparam int SAMPLE_W = 32;
   localparam int IQ_I_W   = 16;
   localparam int IQ_Q_W   = 16;
   localparam int IQ_I_MSB = 31;
   localparam int IQ_I_LSB = 16;
   localparam int IQ_Q_MSB = 15;
   localparam int IQ_Q_LSB = 0;
   localparam int SUM_W    = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } cap_state_e;

   // I and Q share a width, so one helper widens either field.
   function automatic logic [SUM_W-1:0] sext_field(input logic [IQ_I_W-1:0] v);
      return {{(SUM_W-IQ_I_W){v[IQ_I_W-1]}}, v};
   endfunction

endpackage

// File: rtl/axis_sample_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// A read of an address written in the same cycle returns the previous contents.
module capture_ram
   import axis_sample_capture_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [SAMPLE_W-1:0] wr_data,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [SAMPLE_W-1:0] rd_data
);

   logic [SAMPLE_W-1:0] mem [DEPTH];
   logic [SAMPLE_W-1:0] rd_data_q;
   logic [SAMPLE_W-1:0] rd_data_d;

   // Storage is deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_sample_capture.sv
// AXI-Stream I/Q sample capture: stores up to DEPTH armed samples into a
// buffer, keeps signed running sums of I and Q, and offers buffer readback.
module axis_sample_capture
   import axis_sample_capture_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic                arm,
   input  logic                abort,
   input  logic [ADDR_W:0]     cap_len,
   output logic                cap_busy,
   output logic                cap_done,
   output logic [ADDR_W:0]     cap_count,
   output logic [SUM_W-1:0]    sum_i,
   output logic [SUM_W-1:0]    sum_q,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [SAMPLE_W-1:0] rd_data,
   output logic                rd_valid,
   output cap_state_e          dbg_state
);

   localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

   cap_state_e         state_q, state_d;
   logic [ADDR_W:0]    len_q, len_d;
   logic [ADDR_W:0]    count_q, count_d;
   logic [SUM_W-1:0]   sum_i_q, sum_i_d;
   logic [SUM_W-1:0]   sum_q_q, sum_q_d;
   logic               tready_q, tready_d;
   logic               rd_valid_q, rd_valid_d;
   logic               accept;
   logic               wr_en;
   logic [ADDR_W:0]    arm_len;

   // Handshake: a beat transfers on a rising edge where tvalid && tready.
   // tready is low only while in reset and the first cycle after release.
   assign accept  = s_axis_tvalid && tready_q;
   assign arm_len = (cap_len > DEPTH_LEN) ? DEPTH_LEN : cap_len;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      count_d    = count_q;
      sum_i_d    = sum_i_q;
      sum_q_d    = sum_q_q;
      wr_en      = 1'b0;
      tready_d   = 1'b1;
      rd_valid_d = rd_en;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (arm) begin
               len_d   = arm_len;
               count_d = '0;
               sum_i_d = '0;
               sum_q_d = '0;
               state_d = (arm_len == '0) ? ST_DONE : ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            // Abort takes priority, so a beat on the abort edge is dropped.
            if (abort) begin
               state_d = ST_IDLE;
            end else if (accept) begin
               wr_en   = 1'b1;
               count_d = count_q + 1'b1;
               sum_i_d = sum_i_q + sext_field(s_axis_tdata[IQ_I_MSB:IQ_I_LSB]);
               sum_q_d = sum_q_q + sext_field(s_axis_tdata[IQ_Q_MSB:IQ_Q_LSB]);
               if (count_d == len_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         count_q    <= '0;
         sum_i_q    <= '0;
         sum_q_q    <= '0;
         tready_q   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         count_q    <= count_d;
         sum_i_q    <= sum_i_d;
         sum_q_q    <= sum_q_d;
         tready_q   <= tready_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   capture_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (count_q[ADDR_W-1:0]),
      .wr_data (s_axis_tdata),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign s_axis_tready = tready_q;
   assign cap_busy      = (state_q == ST_CAPTURE);
   assign cap_done      = (state_q == ST_DONE);
   assign cap_count     = count_q;
   assign sum_i         = sum_i_q;
   assign sum_q         = sum_q_q;
   assign rd_valid      = rd_valid_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_sample_capture.sv
// Directed bench for axis_sample_capture with a scoreboard on readback data
// and on completed-capture results.
module tb_axis_sample_capture;
   import axis_sample_capture_pkg::*;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = $clog2(DEPTH);

   logic                clk;
   logic                rst_n;
   logic [31:0]         s_axis_tdata;
   logic                s_axis_tvalid;
   logic                s_axis_tready;
   logic                arm;
   logic                abort;
   logic [ADDR_W:0]     cap_len;
   logic                cap_busy;
   logic                cap_done;
   logic [ADDR_W:0]     cap_count;
   logic [31:0]         sum_i;
   logic [31:0]         sum_q;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [31:0]         rd_data;
   logic                rd_valid;
   cap_state_e          dbg_state;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd_exp_q[$];
   logic [74:0] done_exp_q[$];
   logic        done_prev;
   logic [31:0] rd_exp;
   logic [74:0] done_exp;

   axis_sample_capture #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .arm           (arm),
      .abort         (abort),
      .cap_len       (cap_len),
      .cap_busy      (cap_busy),
      .cap_done      (cap_done),
      .cap_count     (cap_count),
      .sum_i         (sum_i),
      .sum_q         (sum_q),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input logic [31:0] d);
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      tick();
      s_axis_tvalid = 1'b0;
   endtask

   task automatic do_arm(input logic [ADDR_W:0] len);
      arm     = 1'b1;
      cap_len = len;
      tick();
      arm     = 1'b0;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
      rd_exp_q.push_back(exp);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_valid) begin
            if (rd_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_valid_unexpected: got data %0h expected no read", rd_data);
            end else begin
               rd_exp = rd_exp_q.pop_front();
               check("rd_data", {64'd0, rd_data}, {64'd0, rd_exp});
            end
         end
         if (cap_done && !done_prev) begin
            if (done_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unexpected: got count %0d expected no completion", cap_count);
            end else begin
               done_exp = done_exp_q.pop_front();
               check("done_result", {21'd0, cap_count, sum_i, sum_q}, {21'd0, done_exp});
            end
         end
      end
      done_prev <= cap_done;
   end

   initial begin
      rst_n = 1'b0;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0;
      arm = 1'b0; abort = 1'b0; cap_len = '0;
      rd_en = 1'b0; rd_addr = '0;
      done_prev = 1'b0;

      // reset state
      #3;
      check("rst_tready", 96'(s_axis_tready), 96'(0));
      check("rst_outputs", {cap_busy, cap_done, rd_valid, cap_count, sum_i, sum_q, rd_data},
            {3'b000, 11'd0, 96'd0});
      tick(); tick();
      rst_n = 1'b1;
      check("tready_pre_edge", 96'(s_axis_tready), 96'(0));
      tick();
      check("tready_post_edge", 96'(s_axis_tready), 96'(1));
      check("state_idle", 96'(dbg_state), 96'(ST_IDLE));

      // a sample in IDLE is discarded
      send_sample(32'h1234_5678);
      check("idle_discard", 96'(cap_count), 96'(0));

      // four back-to-back samples
      done_exp_q.push_back({11'd4, 32'(10), 32'(-10)});
      do_arm(11'd4);
      check("busy_after_arm", {94'd0, cap_busy, cap_done}, {94'd0, 2'b10});
      send_sample(32'h0001_FFFF);
      send_sample(32'h0002_FFFE);
      send_sample(32'h0003_FFFD);
      check("busy_before_last", {94'd0, cap_busy, cap_done}, {94'd0, 2'b10});
      send_sample(32'h0004_FFFC);
      check("done_on_last", {94'd0, cap_busy, cap_done}, {94'd0, 2'b01});
      send_sample(32'h7777_7777);
      check("done_hold", {cap_count, sum_i, sum_q}, {11'd4, 32'(10), 32'(-10)});

      // three samples with gaps, restarted from DONE, then read back
      done_exp_q.push_back({11'd3, 32'(32567), 32'(-32766)});
      do_arm(11'd3);
      send_sample(32'h0064_FFFB);
      tick(); tick();
      send_sample(32'hFED4_0007);
      tick(); tick();
      send_sample(32'h7FFF_8000);
      tick();
      do_read(10'd0, 32'h0064_FFFB);
      do_read(10'd1, 32'hFED4_0007);
      tick();
      do_read(10'd2, 32'h7FFF_8000);
      tick();

      // abort wins over arm; arm during capture ignored; later beats not stored
      do_arm(11'd8);
      send_sample(32'h0005_0006);
      arm = 1'b1; cap_len = 11'd1;
      send_sample(32'h0007_0008);
      arm = 1'b0;
      send_sample(32'h0009_000A);
      check("busy_before_abort", {cap_count, 1'b0, cap_busy}, {11'd3, 1'b0, 1'b1});
      arm = 1'b1; abort = 1'b1; cap_len = 11'd8;
      send_sample(32'hDEAD_BEEF);
      arm = 1'b0; abort = 1'b0;
      check("abort_state", 96'(dbg_state), 96'(ST_IDLE));
      check("abort_retain", {cap_busy, cap_done, cap_count, sum_i, sum_q},
            {2'b00, 11'd3, 32'(21), 32'(24)});
      send_sample(32'h1111_2222);
      send_sample(32'h3333_4444);
      check("idle_after_abort", {cap_count, sum_i}, {11'd3, 32'(21)});
      do_read(10'd2, 32'h0009_000A);
      do_read(10'd3, 32'h0004_FFFC);
      tick();

      // zero length goes straight to DONE
      done_exp_q.push_back({11'd0, 32'd0, 32'd0});
      do_arm(11'd0);
      check("zero_len_done", {94'd0, cap_busy, cap_done}, {94'd0, 2'b01});
      check("zero_len_sums", {cap_count, sum_i, sum_q}, {11'd0, 64'd0});
      tick();

      // length beyond DEPTH clamps; most negative I accumulates
      done_exp_q.push_back({11'd1024, 32'hFE00_0000, 32'd1024});
      do_arm(11'd1025);
      s_axis_tdata  = 32'h8000_0001;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < DEPTH + 6; i++) tick();
      s_axis_tvalid = 1'b0;
      check("clamp_result", {cap_done, cap_count, sum_i, sum_q},
            {1'b1, 11'd1024, 32'hFE00_0000, 32'd1024});
      do_read(10'd1023, 32'h8000_0001);
      do_read(10'd0, 32'h8000_0001);
      tick();

      // reset in the middle of a capture
      do_arm(11'd8);
      for (int i = 0; i < 5; i++) send_sample(32'h0001_0001 * (i + 1));
      check("busy_before_reset", {cap_busy, cap_count}, {1'b1, 11'd5});
      do_read(10'd3, 32'h0004_0004);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tready", 96'(s_axis_tready), 96'(0));
      check("mid_rst_outputs", {cap_busy, cap_done, rd_valid, cap_count, sum_i, sum_q, rd_data},
            {3'b000, 11'd0, 96'd0});
      check("mid_rst_state", 96'(dbg_state), 96'(ST_IDLE));
      tick(); tick();
      rst_n = 1'b1;
      check("rel_tready_pre", 96'(s_axis_tready), 96'(0));
      tick();
      check("rel_tready_post", 96'(s_axis_tready), 96'(1));

      tick(); tick();
      check("rd_queue_empty", 96'(rd_exp_q.size()), 96'(0));
      check("done_queue_empty", 96'(done_exp_q.size()), 96'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
